// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the I/D memory-port arbiter.
// Line offset helper keeps the base-address masking consistent with LINE_WORDS.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_e;

    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

    localparam int unsigned LINE_WORDS_DEF = 4;

    // Byte offset bits of a line of 32-bit words.
    function automatic int unsigned line_off(input int unsigned line_words);
        return $clog2(line_words) + 2;
    endfunction

    localparam int unsigned LINE_OFF = line_off(LINE_WORDS_DEF);

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin picker: a lone request wins outright, a tie goes
// to the requester that was not served last.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       pick,
    output logic       valid
);

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        valid = |req;
        pick  = REQ_I;
        if (&req) begin
            pick = ~last;
        end else if (req[REQ_D]) begin
            pick = REQ_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one main-memory port between the I-cache refill engine and the
// D-cache refill/writeback engine, sequencing one line-sized burst at a time.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_rvalid,
    output logic              i_done,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_wready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_rvalid,
    output logic              d_done,

    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned     OFF       = line_off(LINE_WORDS);
    localparam int unsigned     BEAT_W    = $clog2(LINE_WORDS);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W'(1) << OFF) - ADDR_W'(1));
    localparam logic [BEAT_W-1:0] BEAT_MAX  = BEAT_W'(LINE_WORDS - 1);

    state_e              state_q, state_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic                last_gnt_q, last_gnt_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic                we_q, we_d;

    logic arb_pick;
    logic arb_valid;
    logic serving;
    logic beat_fire;
    logic beat_last;

    rr_arb2 u_rr_arb2 (
        .req   ({d_req, i_req}),
        .last  (last_gnt_q),
        .pick  (arb_pick),
        .valid (arb_valid)
    );

    assign serving   = (state_q != IDLE);
    assign beat_fire = serving && mem_ready;
    assign beat_last = (beat_q == BEAT_MAX);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            last_gnt_q <= REQ_I;
            base_q     <= '0;
            we_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            last_gnt_q <= last_gnt_d;
            base_q     <= base_d;
            we_q       <= we_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        last_gnt_d = last_gnt_q;
        base_d     = base_q;
        we_d       = we_q;
        unique case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    state_d = (arb_pick == REQ_D) ? SERVE_D : SERVE_I;
                    base_d  = ((arb_pick == REQ_D) ? d_addr : i_addr) & LINE_MASK;
                    we_d    = (arb_pick == REQ_D) && d_we;
                    beat_d  = '0;
                end
            end
            SERVE_I, SERVE_D: begin
                if (beat_fire) begin
                    // Power-of-two burst length lets the counter wrap on its own.
                    beat_d = beat_q + 1'b1;
                    if (beat_last) begin
                        state_d    = IDLE;
                        last_gnt_d = (state_q == SERVE_D) ? REQ_D : REQ_I;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        i_gnt     = (state_q == SERVE_I);
        d_gnt     = (state_q == SERVE_D);
        i_rdata   = '0;
        i_rvalid  = 1'b0;
        i_done    = 1'b0;
        d_rdata   = '0;
        d_rvalid  = 1'b0;
        d_done    = 1'b0;
        d_wready  = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (serving) begin
            mem_req  = 1'b1;
            mem_we   = we_q;
            mem_addr = base_q + (ADDR_W'(beat_q) << 2);
            if (state_q == SERVE_D) begin
                d_done = beat_fire && beat_last;
                if (we_q) begin
                    // Write data is taken straight from the D-cache, not buffered.
                    mem_wdata = d_wdata;
                    d_wready  = mem_ready;
                end else begin
                    d_rdata  = mem_rdata;
                    d_rvalid = mem_ready;
                end
            end else begin
                i_done   = beat_fire && beat_last;
                i_rdata  = mem_rdata;
                i_rvalid = mem_ready;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scenario bench for mem_arbiter: a negedge monitor pops expected beats from a
// scoreboard, while each scenario task checks its cycle-exact behaviour.
module tb_mem_arbiter;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned LW     = 4;
    localparam logic [31:0] RD_XOR = 32'h5A5A_0000;
    localparam logic [31:0] WD_TAG = 32'hD000_0000;

    logic              clk;
    logic              rst;
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic [DATA_W-1:0] i_rdata;
    logic              i_rvalid;
    logic              i_done;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_wready;
    logic [DATA_W-1:0] d_rdata;
    logic              d_rvalid;
    logic              d_done;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;

    mem_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .LINE_WORDS (LW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_gnt     (i_gnt),
        .i_rdata   (i_rdata),
        .i_rvalid  (i_rvalid),
        .i_done    (i_done),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_wready  (d_wready),
        .d_rdata   (d_rdata),
        .d_rvalid  (d_rvalid),
        .d_done    (d_done),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: read data is a fixed function of the word address.
    assign mem_rdata = mem_addr ^ RD_XOR;

    typedef struct {
        logic        side;   // 0 = I, 1 = D
        logic [31:0] addr;
        logic        we;
        logic [31:0] data;
        logic        last;
    } beat_t;

    beat_t sb[$];
    beat_t mon_e;
    int    checks   = 0;
    int    failures = 0;
    int    widx;

    task automatic push_burst(input logic side, input logic [31:0] base, input logic we);
        for (int b = 0; b < int'(LW); b++) begin
            beat_t e;
            e.side = side;
            e.addr = base + 32'(4 * b);
            e.we   = we;
            e.data = we ? (WD_TAG + 32'(b)) : (e.addr ^ RD_XOR);
            e.last = (b == int'(LW) - 1);
            sb.push_back(e);
        end
    endtask

    // Drive point just after the rising edge; samples happen on the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!rst && mem_req && mem_ready) begin
            if (sb.size() == 0) begin
                checks++; failures++;
                $display("FAIL sb_unexpected_beat mem_addr=%h", mem_addr);
            end else begin
                mon_e = sb.pop_front();
                checks++;
                if (mem_addr !== mon_e.addr) begin
                    failures++;
                    $display("FAIL sb_addr got=%h exp=%h", mem_addr, mon_e.addr);
                end
                checks++;
                if (mem_we !== mon_e.we) begin
                    failures++;
                    $display("FAIL sb_we got=%b exp=%b", mem_we, mon_e.we);
                end
                checks++;
                if ({i_gnt, d_gnt} !== (mon_e.side ? 2'b01 : 2'b10)) begin
                    failures++;
                    $display("FAIL sb_gnt got i=%b d=%b exp_side=%b", i_gnt, d_gnt, mon_e.side);
                end
                checks++;
                if (mon_e.we) begin
                    if ({d_wready, mem_wdata} !== {1'b1, mon_e.data}) begin
                        failures++;
                        $display("FAIL sb_wdata got wready=%b data=%h exp=%h", d_wready, mem_wdata, mon_e.data);
                    end
                end else if (mon_e.side) begin
                    if ({d_rvalid, d_rdata} !== {1'b1, mon_e.data}) begin
                        failures++;
                        $display("FAIL sb_d_rdata got rvalid=%b data=%h exp=%h", d_rvalid, d_rdata, mon_e.data);
                    end
                end else begin
                    if ({i_rvalid, i_rdata} !== {1'b1, mon_e.data}) begin
                        failures++;
                        $display("FAIL sb_i_rdata got rvalid=%b data=%h exp=%h", i_rvalid, i_rdata, mon_e.data);
                    end
                end
                checks++;
                if ((mon_e.side ? d_done : i_done) !== mon_e.last) begin
                    failures++;
                    $display("FAIL sb_done got=%b exp=%b", mon_e.side ? d_done : i_done, mon_e.last);
                end
                checks++;
                if ((mon_e.side ? i_rvalid : d_rvalid) !== 1'b0) begin
                    failures++;
                    $display("FAIL sb_other_rvalid got=1 exp=0");
                end
            end
        end
    end

    task automatic check_sb_empty(input string name);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL %s_sb_left got=%0d exp=0", name, sb.size());
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if ({i_gnt, i_rvalid, i_done, d_gnt, d_wready, d_rvalid, d_done, mem_req, mem_we} !== 9'b0 ||
            {i_rdata, d_rdata, mem_addr, mem_wdata} !== 128'b0) begin
            failures++;
            $display("FAIL %s_outputs_zero got gnt=%b%b mem_req=%b mem_addr=%h", name, i_gnt, d_gnt, mem_req, mem_addr);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        sample();
        check_all_zero("reset");
        tick();
        rst = 1'b0;
        sample();
        check_all_zero("post_reset");
    endtask

    task automatic test_i_refill();
        tick();
        i_addr = 32'h0000_1234; i_req = 1'b1; mem_ready = 1'b1;
        push_burst(1'b0, 32'h0000_1230, 1'b0);
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (c == 5) i_req = 1'b0;
            sample();
            if (c <= 4) begin
                checks++;
                if ({i_gnt, i_rvalid, i_done, mem_addr} !== {2'b11, (c == 4), 32'h0000_1230 + 32'(4 * (c - 1))}) begin
                    failures++;
                    $display("FAIL i_refill_c%0d got gnt=%b rvalid=%b done=%b addr=%h", c, i_gnt, i_rvalid, i_done, mem_addr);
                end
            end else begin
                checks++;
                if ({i_gnt, mem_req} !== 2'b00) begin
                    failures++;
                    $display("FAIL i_refill_idle got gnt=%b mem_req=%b exp=0", i_gnt, mem_req);
                end
            end
        end
        check_sb_empty("i_refill");
    endtask

    task automatic test_tie_alternate();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        i_addr = 32'h0000_3008; d_addr = 32'h0000_400C; d_we = 1'b0;
        i_req = 1'b1; d_req = 1'b1; mem_ready = 1'b1;
        push_burst(1'b1, 32'h0000_4000, 1'b0);
        push_burst(1'b0, 32'h0000_3000, 1'b0);
        push_burst(1'b1, 32'h0000_4000, 1'b0);
        push_burst(1'b0, 32'h0000_3000, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 20) begin
                i_req = 1'b0; d_req = 1'b0;
            end
            sample();
            checks++;
            if ((k - 1) % 5 == 4) begin
                if ({i_gnt, d_gnt, mem_req} !== 3'b000) begin
                    failures++;
                    $display("FAIL tie_bubble_k%0d got gnt=%b%b mem_req=%b exp=000", k, i_gnt, d_gnt, mem_req);
                end
            end else begin
                if ({i_gnt, d_gnt} != ((((k - 1) / 5) % 2 == 0) ? 2'b01 : 2'b10)) begin
                    failures++;
                    $display("FAIL tie_order_k%0d got i=%b d=%b", k, i_gnt, d_gnt);
                end
            end
        end
        check_sb_empty("tie");
    endtask

    task automatic test_writeback();
        int pulses;
        pulses = 0;
        tick();
        d_addr = 32'h0000_2000; d_we = 1'b1; d_req = 1'b1; mem_ready = 1'b1;
        widx = 0; d_wdata = WD_TAG;
        push_burst(1'b1, 32'h0000_2000, 1'b1);
        for (int c = 1; c <= 8; c++) begin
            tick();
            mem_ready = (c % 2 == 1);
            d_wdata   = WD_TAG + 32'(widx);
            if (c == 8) d_req = 1'b0;
            sample();
            if (c <= 7) begin
                checks++;
                if ({d_wready, d_done} !== {mem_ready, (c == 7)}) begin
                    failures++;
                    $display("FAIL wb_c%0d got wready=%b done=%b exp wready=%b done=%b", c, d_wready, d_done, mem_ready, (c == 7));
                end
                if (d_wready === 1'b1) begin
                    pulses++;
                    widx++;
                    checks++;
                    if (mem_wdata !== d_wdata) begin
                        failures++;
                        $display("FAIL wb_wdata_c%0d got=%h exp=%h", c, mem_wdata, d_wdata);
                    end
                end
            end else begin
                checks++;
                if ({d_gnt, mem_req} !== 2'b00) begin
                    failures++;
                    $display("FAIL wb_idle got gnt=%b mem_req=%b exp=0", d_gnt, mem_req);
                end
            end
        end
        checks++;
        if (pulses != 4) begin
            failures++;
            $display("FAIL wb_pulses got=%0d exp=4", pulses);
        end
        d_we = 1'b0;
        check_sb_empty("wb");
    endtask

    task automatic test_addr_change();
        tick();
        d_addr = 32'h0000_5004; d_we = 1'b0; d_req = 1'b1; mem_ready = 1'b1;
        push_burst(1'b1, 32'h0000_5000, 1'b0);
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (c == 2) begin
                d_addr = 32'h0000_9000; d_we = 1'b1;
            end
            if (c == 5) d_req = 1'b0;
            sample();
            if (c <= 4) begin
                checks++;
                if ({mem_we, mem_addr} !== {1'b0, 32'h0000_5000 + 32'(4 * (c - 1))}) begin
                    failures++;
                    $display("FAIL addr_latch_c%0d got we=%b addr=%h", c, mem_we, mem_addr);
                end
            end
        end
        d_we = 1'b0;
        check_sb_empty("addr_change");
    endtask

    task automatic test_stall();
        tick();
        d_addr = 32'h0000_A000; d_we = 1'b0; d_req = 1'b1; mem_ready = 1'b1;
        push_burst(1'b1, 32'h0000_A000, 1'b0);
        for (int c = 1; c <= 10; c++) begin
            tick();
            mem_ready = !(c >= 3 && c <= 7);
            if (c == 10) d_req = 1'b0;
            sample();
            if (c >= 3 && c <= 7) begin
                checks++;
                if ({d_gnt, d_rvalid, d_done, mem_addr} !== {3'b100, 32'h0000_A008}) begin
                    failures++;
                    $display("FAIL stall_c%0d got gnt=%b rvalid=%b done=%b addr=%h", c, d_gnt, d_rvalid, d_done, mem_addr);
                end
            end else if (c == 9) begin
                checks++;
                if (d_done !== 1'b1) begin
                    failures++;
                    $display("FAIL stall_done got=%b exp=1", d_done);
                end
            end else if (c == 10) begin
                checks++;
                if (mem_req !== 1'b0) begin
                    failures++;
                    $display("FAIL stall_idle got mem_req=%b exp=0", mem_req);
                end
            end
        end
        check_sb_empty("stall");
    endtask

    task automatic test_reset_abort();
        tick();
        i_addr = 32'h0000_6000; i_req = 1'b1; mem_ready = 1'b1;
        push_burst(1'b0, 32'h0000_6000, 1'b0);
        for (int c = 1; c <= 3; c++) begin
            tick();
            if (c == 3) begin
                rst = 1'b1; i_req = 1'b0;
                #1;
                check_all_zero("abort");
                sb.delete();
            end else begin
                sample();
                checks++;
                if (i_gnt !== 1'b1) begin
                    failures++;
                    $display("FAIL abort_pre_gnt_c%0d got=%b exp=1", c, i_gnt);
                end
            end
        end
        tick();
        rst = 1'b0;
        i_addr = 32'h0000_7000; d_addr = 32'h0000_8000; d_we = 1'b0;
        i_req = 1'b1; d_req = 1'b1;
        push_burst(1'b1, 32'h0000_8000, 1'b0);
        push_burst(1'b0, 32'h0000_7000, 1'b0);
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (c == 5) d_req = 1'b0;
            if (c == 10) i_req = 1'b0;
            sample();
            if (c == 1) begin
                checks++;
                if ({i_gnt, d_gnt, mem_addr} !== {2'b01, 32'h0000_8000}) begin
                    failures++;
                    $display("FAIL abort_regrant got i=%b d=%b addr=%h exp d at 00008000", i_gnt, d_gnt, mem_addr);
                end
            end else if (c == 6) begin
                checks++;
                if ({i_gnt, d_gnt, mem_addr} !== {2'b10, 32'h0000_7000}) begin
                    failures++;
                    $display("FAIL abort_second got i=%b d=%b addr=%h exp i at 00007000", i_gnt, d_gnt, mem_addr);
                end
            end
        end
        check_sb_empty("abort");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; mem_ready = 1'b0; widx = 0;
        test_reset();
        test_i_refill();
        test_tie_alternate();
        test_writeback();
        test_addr_change();
        test_stall();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
